// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache.
// Load hits return data in the same cycle; misses and all stores stall the pipeline.
module data_cache #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_WIDTH-1:0]   cpu_addr,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
  output logic [DATA_WIDTH-1:0]   cpu_rdata,
  output logic                    stall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_en,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int WORD_BITS  = $clog2(LINE_WORDS);
  localparam int INDEX_BITS = $clog2(NUM_LINES);
  localparam int TAG_BITS   = ADDR_WIDTH - 2 - WORD_BITS - INDEX_BITS;
  localparam int BYTES      = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t                  state;
  logic [WORD_BITS-1:0]    cnt;
  logic [TAG_BITS-1:0]     refill_tag;
  logic [INDEX_BITS-1:0]   refill_index;
  logic [NUM_LINES-1:0]    valid;
  logic [TAG_BITS-1:0]     tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0]   data_mem [NUM_LINES*LINE_WORDS];

  logic [TAG_BITS-1:0]     cpu_tag;
  logic [INDEX_BITS-1:0]   cpu_index;
  logic [WORD_BITS-1:0]    cpu_word;
  logic                    hit;
  logic                    last_word;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic [DATA_WIDTH-1:0]   merged;

  assign cpu_tag   = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign cpu_index = cpu_addr[2+WORD_BITS +: INDEX_BITS];
  assign cpu_word  = cpu_addr[2 +: WORD_BITS];
  assign hit       = valid[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign last_word = (cnt == WORD_BITS'(LINE_WORDS - 1));
  assign cur_word  = data_mem[{cpu_index, cpu_word}];

  assign cpu_rdata = (state == IDLE && cpu_req && !cpu_we && hit) ? cur_word : '0;

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = cpu_req && (cpu_we || !hit);
      REFILL:  stall = 1'b1;
      WRITE:   stall = !mem_ready;
      default: stall = 1'b0;
    endcase
  end

  // Store hits merge only the enabled byte lanes into the cached word.
  always_comb begin
    merged = cur_word;
    for (int b = 0; b < BYTES; b++) begin
      if (cpu_byte_en[b]) merged[8*b +: 8] = cpu_wdata[8*b +: 8];
    end
  end

  // Memory-side outputs decode from the state register, so reset drops mem_req at once.
  assign mem_req     = (state != IDLE);
  assign mem_we      = (state == WRITE);
  assign mem_addr    = (state == WRITE) ? (cpu_addr & ~ADDR_WIDTH'(3))
                                        : {refill_tag, refill_index, cnt, 2'b00};
  assign mem_wdata   = (state == WRITE) ? cpu_wdata : '0;
  assign mem_byte_en = (state == WRITE) ? cpu_byte_en : '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      valid        <= '0;
      refill_tag   <= '0;
      refill_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              state <= WRITE;
            end else if (!hit) begin
              state        <= REFILL;
              refill_tag   <= cpu_tag;
              refill_index <= cpu_index;
              cnt          <= '0;
            end
          end
        end
        REFILL: begin
          if (mem_ready) begin
            if (last_word) begin
              cnt                 <= '0;
              valid[refill_index] <= 1'b1;
              state               <= IDLE;
            end else begin
              cnt <= cnt + WORD_BITS'(1);
            end
          end
        end
        WRITE: begin
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data and tag arrays carry no reset; the valid bits alone guard them.
  always_ff @(posedge clk) begin
    if (state == REFILL && mem_ready) begin
      data_mem[{refill_index, cnt}] <= mem_rdata;
      if (last_word) tag_mem[refill_index] <= refill_tag;
    end
    if (state == WRITE && mem_ready && hit) begin
      data_mem[{cpu_index, cpu_word}] <= merged;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed vector table plus reset and idle sequences,
// with a 2-cycle-per-word backing memory model.
module tb_data_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byte_en;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_en;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  data_cache dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    int          exp_reads;
    int          exp_writes;
    int          exp_stalls;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] bmem [logic [31:0]];
  logic [31:0] read_q [$];
  int          reads = 0;
  int          writes = 0;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wbe;
  int          checks = 0;
  int          passed = 0;

  logic [31:0] got_rdata;
  int          got_stalls, got_reads, got_writes, read_start;
  logic        got_done;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Backing memory: each word completes in the second cycle of its request.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = mem_req ? 1 : 0;
      end else if (mem_req) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          mem_ready = 1'b1;
          mem_rdata = mem_we ? 32'h0 : mem_read(mem_addr);
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Transaction log; completed stores update the backing memory with byte lanes.
  always @(posedge clk) begin
    logic [31:0] w;
    if (!rst && mem_req && mem_ready) begin
      if (mem_we) begin
        w = mem_read(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_byte_en[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
        bmem[mem_addr] = w;
        writes++;
        last_waddr = mem_addr;
        last_wdata = mem_wdata;
        last_wbe   = mem_byte_en;
      end else begin
        reads++;
        read_q.push_back(mem_addr);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Drives one access right after a negedge and returns after its completing edge.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be);
    int r0, w0;
    r0 = reads;
    w0 = writes;
    read_start  = read_q.size();
    cpu_req     = 1'b1;
    cpu_we      = we;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    cpu_byte_en = be;
    got_stalls  = 0;
    got_done    = 1'b0;
    got_rdata   = '0;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (!stall) begin
        got_rdata = cpu_rdata;
        got_done  = 1'b1;
        break;
      end
      got_stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    cpu_req    = 1'b0;
    got_reads  = reads - r0;
    got_writes = writes - w0;
  endtask

  task automatic runAccess(input vec_t v);
    applyStimulus(v.we, v.addr, v.wdata, v.be);
    checkOutput({v.name, "_done"}, 32'(got_done), 32'd1);
    checkOutput({v.name, "_rdata"}, got_rdata, v.exp_rdata);
    checkOutput({v.name, "_stalls"}, got_stalls, v.exp_stalls);
    checkOutput({v.name, "_reads"}, got_reads, v.exp_reads);
    checkOutput({v.name, "_writes"}, got_writes, v.exp_writes);
    if (v.exp_reads == 4 && read_q.size() >= read_start + 4) begin
      for (int k = 0; k < 4; k++)
        checkOutput({v.name, "_refill_addr"}, read_q[read_start + k], (v.addr & ~32'hF) + 32'(4 * k));
    end
    if (v.we) begin
      checkOutput({v.name, "_waddr"}, last_waddr, v.addr & ~32'h3);
      checkOutput({v.name, "_wdata"}, last_wdata, v.wdata);
      checkOutput({v.name, "_wbe"}, 32'(last_wbe), 32'(v.be));
    end
  endtask

  initial begin
    int   r0;
    logic seen_req;
    vecs[0]  = '{"cold_ld100",  1'b0, 32'h100,  32'h0,        4'h0, 32'hC0DE0100, 4, 0, 9};
    vecs[1]  = '{"hit_ld10c",   1'b0, 32'h10C,  32'h0,        4'h0, 32'hC0DE010C, 0, 0, 0};
    vecs[2]  = '{"st104_hit",   1'b1, 32'h104,  32'h000000AA, 4'h1, 32'h0,        0, 1, 2};
    vecs[3]  = '{"ld104_merge", 1'b0, 32'h104,  32'h0,        4'h0, 32'hC0DE01AA, 0, 0, 0};
    vecs[4]  = '{"hit_ld108",   1'b0, 32'h108,  32'h0,        4'h0, 32'hC0DE0108, 0, 0, 0};
    vecs[5]  = '{"st2000_miss", 1'b1, 32'h2000, 32'h12345678, 4'hF, 32'h0,        0, 1, 2};
    vecs[6]  = '{"ld2000",      1'b0, 32'h2000, 32'h0,        4'h0, 32'h12345678, 4, 0, 9};
    vecs[7]  = '{"ld500_confl", 1'b0, 32'h500,  32'h0,        4'h0, 32'hC0DE0500, 4, 0, 9};
    vecs[8]  = '{"ld100_again", 1'b0, 32'h100,  32'h0,        4'h0, 32'hC0DE0100, 4, 0, 9};
    vecs[9]  = '{"ld104_wt",    1'b0, 32'h104,  32'h0,        4'h0, 32'hC0DE01AA, 0, 0, 0};
    vecs[10] = '{"st50c_miss",  1'b1, 32'h50E,  32'hAABB0000, 4'hC, 32'h0,        0, 1, 2};
    vecs[11] = '{"ld10c_kept",  1'b0, 32'h10C,  32'h0,        4'h0, 32'hC0DE010C, 0, 0, 0};
    vecs[12] = '{"ld50c",       1'b0, 32'h50C,  32'h0,        4'h0, 32'hAABB050C, 4, 0, 9};

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_byte_en = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_stall", 32'(stall), 32'd0);
    checkOutput("rst_rdata", cpu_rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // No request: no stall and no memory traffic.
    seen_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      if (mem_req || stall) seen_req = 1'b1;
    end
    checkOutput("idle_quiet", 32'(seen_req), 32'd0);
    @(negedge clk);

    for (int i = 0; i < 13; i++) runAccess(vecs[i]);

    // Reset during the third word of a refill.
    r0 = reads;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h3000;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (reads - r0 >= 2) break;
    end
    checkOutput("mid_refill_reads", reads - r0, 2);
    #2;
    checkOutput("mid_refill_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    cpu_req = 1'b0;
    #1;
    checkOutput("rst_drop_req", 32'(mem_req), 32'd0);
    checkOutput("rst_drop_stall", 32'(stall), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runAccess('{"post_rst_ld100", 1'b0, 32'h100,  32'h0, 4'h0, 32'hC0DE0100, 4, 0, 9});
    runAccess('{"post_rst_ld2000", 1'b0, 32'h2000, 32'h0, 4'h0, 32'h12345678, 4, 0, 9});
    runAccess('{"post_rst_ld3000", 1'b0, 32'h3004, 32'h0, 4'h0, 32'hC0DE3004, 4, 0, 9});

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
